cs_y_fifo: RTL and testbench

Output buffer stage directly downstream of `CS`. It samples `CS`'s 10-bit `Y` every clock after the filter's 8-cycle warm-up and discards the warm-up samples. Accepted samples are stored in a synchronous FIFO and offered to the next consumer over a valid/ready handshake. This decouples the free-running `CS` pipeline from back-pressured sinks such as a result writer or checker.

---
 rtl/cs_y_fifo.sv | 92 +++++++++
 tb/tb_cs_y_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cs_y_fifo.sv
// Output buffer behind CS: discards the filter's warm-up samples, then queues Y into a
// synchronous FIFO with a valid/ready read port. Optional min/max tracking: CS_Y_STATS_EN.
module cs_y_fifo #(
   parameter int DW     = 10,
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int WARMUP = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] y_in,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW:0]   level,
   output logic          warm,
   output logic          overflow
`ifdef CS_Y_STATS_EN
   ,
   output logic [DW-1:0] y_min,
   output logic [DW-1:0] y_max
`endif
);

   localparam int CW = $clog2(WARMUP + 1);

   logic [CW-1:0] wcnt;
   logic [AW:0]   wptr, rptr;
   logic [DW-1:0] mem [DEPTH];
   logic          full, empty;
   logic          push, pop, drop;

   // One extra pointer bit distinguishes full from empty when the low bits match.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   assign pop  = !empty && out_ready;
   assign push = warm && (!full || pop);
   assign drop = warm && full && !pop;

   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt <= '0;
         warm <= 1'b0;
      end else if (!warm) begin
         wcnt <= wcnt + CW'(1);
         if (wcnt == CW'(WARMUP - 1))
            warm <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + (AW+1)'(1);
         if (pop)
            rptr <= rptr + (AW+1)'(1);
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
         if (drop)
            overflow <= 1'b1;
      end
   end

   // Storage is not reset; out_data is masked to zero while empty instead.
   always_ff @(posedge clk) begin
      if (push)
         mem[wptr[AW-1:0]] <= y_in;
   end

`ifdef CS_Y_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y_min <= '1;
         y_max <= '0;
      end else if (push) begin
         if (y_in < y_min)
            y_min <= y_in;
         if (y_in > y_max)
            y_max <= y_in;
      end
   end
`endif

endmodule

// File: tb/tb_cs_y_fifo.sv
// Randomized bench for cs_y_fifo against a queue-based model, plus directed literal checks.
module tb_cs_y_fifo;
   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] y_in = '0;
   logic       out_ready = 1'b0;
   logic [9:0] out_data;
   logic       out_valid;
   logic [4:0] level;
   logic       warm;
   logic       overflow;
`ifdef CS_Y_STATS_EN
   logic [9:0] y_min, y_max;
`endif

   int checks = 0;
   int errors = 0;

   cs_y_fifo dut (
      .clk(clk), .reset(reset), .y_in(y_in),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .warm(warm), .overflow(overflow)
`ifdef CS_Y_STATS_EN
      , .y_min(y_min), .y_max(y_max)
`endif
   );

   always #5 clk = ~clk;

   // behavioural model
   int         m_cnt = 0;
   bit         m_warm = 0, m_ovf = 0, m_pop;
   logic [9:0] q[$];
   logic [9:0] m_min = 10'h3FF, m_max = 10'h000;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cnt = 0; m_warm = 0; m_ovf = 0; q.delete();
         m_min = 10'h3FF; m_max = 10'h000;
      end else if (!m_warm) begin
         m_cnt++;
         if (m_cnt == 8) m_warm = 1;
      end else begin
         m_pop = (q.size() > 0) && out_ready;
         if (m_pop) void'(q.pop_front());
         if (q.size() < 16) begin
            q.push_back(y_in);
            if (y_in < m_min) m_min = y_in;
            if (y_in > m_max) m_max = y_in;
         end else
            m_ovf = 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle compare against the model
   always @(negedge clk) begin
      chk("m_warm", 32'(warm), 32'(m_warm));
      chk("m_level", 32'(level), 32'(q.size()));
      chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("m_data", 32'(out_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
`ifdef CS_Y_STATS_EN
      chk("m_min", 32'(y_min), 32'(m_min));
      chk("m_max", 32'(y_max), 32'(m_max));
`endif
   end

   task automatic step(input logic [9:0] y, input bit r);
      y_in = y; out_ready = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   // called at a falling edge; returns just after release, before the next rising edge
   task automatic do_reset(input bit check_now);
      #2 reset = 1'b0;
      #1;
      if (check_now) begin
         chk("rst_level", 32'(level), 32'd0);
         chk("rst_valid", 32'(out_valid), 32'd0);
         chk("rst_warm", 32'(warm), 32'd0);
         chk("rst_ovf", 32'(overflow), 32'd0);
         chk("rst_data", 32'(out_data), 32'd0);
      end
      @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic warmup(input logic [9:0] y);
      repeat (8) step(y, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;

      // reset and warm-up
      repeat (7) step(10'h155, 1'b1);
      chk("warm_e7", 32'(warm), 32'd0);
      step(10'h155, 1'b1);
      chk("warm_e8", 32'(warm), 32'd1);
      chk("valid_e8", 32'(out_valid), 32'd0);
      step(10'h001, 1'b1);
      chk("first_data", 32'(out_data), 32'h001);
      chk("first_valid", 32'(out_valid), 32'd1);

      // streaming, no back-pressure
      for (int i = 0; i < 100; i++) begin
         step(10'(i), 1'b1);
         chk("stream_lvl", 32'(level <= 5'd1), 32'd1);
      end
      chk("stream_ovf", 32'(overflow), 32'd0);

      // fill and overflow
      @(negedge clk);
      do_reset(1'b0);
      warmup(10'h3AA);
      for (int i = 0; i < 20; i++) begin
         step(10'(i), 1'b0);
         if (i == 15) begin
            chk("fill_lvl16", 32'(level), 32'd16);
            chk("fill_ovf0", 32'(overflow), 32'd0);
         end
         if (i == 16) chk("fill_ovf1", 32'(overflow), 32'd1);
      end
      for (int k = 0; k < 16; k++) begin
         chk("drain_data", 32'(out_data), 32'(k));
         step(10'(10'h200 + k), 1'b1);
      end

      // full with simultaneous push and pop
      do_reset(1'b0);
      warmup(10'h000);
      for (int i = 0; i < 16; i++) step(10'(i), 1'b0);
      chk("full_lvl", 32'(level), 32'd16);
      step(10'h3FF, 1'b1);
      chk("pp_lvl", 32'(level), 32'd16);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_head", 32'(out_data), 32'd1);
      for (int k = 0; k < 15; k++) step(10'(10'h100 + k), 1'b1);
      chk("pp_last", 32'(out_data), 32'h3FF);

      // mid-stream reset
      do_reset(1'b0);
      warmup(10'h000);
      repeat (5) step(10'h0AB, 1'b0);
      chk("mid_lvl5", 32'(level), 32'd5);
      do_reset(1'b1);
      repeat (8) step(10'h055, 1'b1);
      chk("mid_warm", 32'(warm), 32'd1);
      chk("mid_lvl0", 32'(level), 32'd0);
      step(10'h066, 1'b1);
      chk("mid_lvl1", 32'(level), 32'd1);
      chk("mid_data", 32'(out_data), 32'h066);

`ifdef CS_Y_STATS_EN
      do_reset(1'b0);
      warmup(10'h000);
      step(10'h080, 1'b0);
      step(10'h010, 1'b0);
      step(10'h3F0, 1'b0);
      chk("st_min", 32'(y_min), 32'h010);
      chk("st_max", 32'(y_max), 32'h3F0);
      repeat (13) step(10'h100, 1'b0);
      step(10'h000, 1'b0);
      chk("st_drop_min", 32'(y_min), 32'h010);
      chk("st_drop_ovf", 32'(overflow), 32'd1);
`endif

      // randomized traffic with varying back-pressure and occasional resets
      do_reset(1'b0);
      for (int blk = 0; blk < 10; blk++) begin
         int bias = $urandom_range(0, 4);
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 399) == 0)
               do_reset(1'b1);
            step(10'($urandom_range(0, 1023)), $urandom_range(0, 3) < bias);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
